// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a valid/ready handshake, a 2-entry skid buffer,
// freeze/flush control and a saturating stall counter.
module pipe_stage_skid_reg #(
  parameter int unsigned       DATA_W      = 64,
  parameter logic [DATA_W-1:0] FLUSH_VALUE = '0,
  parameter bit                FLUSH_PRIO  = 1'b1,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  main_q;
  logic [DATA_W-1:0]  skid_q;
  logic [CNT_W-1:0]   stall_q;

  logic eff_flush;
  logic eff_freeze;
  logic in_fire;
  logic out_fire;
  logic stall_inc;

  assign eff_flush  = flush_i & (logic'(FLUSH_PRIO) | ~freeze_i);
  assign eff_freeze = freeze_i & ~eff_flush;

  // Ready depends only on registered state and the stage controls, never on out_ready_i.
  assign in_ready_o  = (state_q != StFull) & ~freeze_i & ~flush_i;
  assign out_valid_o = (state_q != StEmpty) & ~freeze_i & ~flush_i;
  assign out_data_o  = main_q;
  assign stall_cnt_o = stall_q;

  assign in_fire   = in_valid_i & in_ready_o;
  assign out_fire  = out_valid_o & out_ready_i;
  assign stall_inc = (state_q != StEmpty) & ~out_fire & ~eff_flush;

  always_comb begin
    occupancy_o = 2'd0;
    unique case (state_q)
      StEmpty: occupancy_o = 2'd0;
      StOne:   occupancy_o = 2'd1;
      StFull:  occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= FLUSH_VALUE;
      skid_q  <= FLUSH_VALUE;
      stall_q <= '0;
    end else begin
      if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (eff_flush) begin
        state_q <= StEmpty;
        main_q  <= FLUSH_VALUE;
        skid_q  <= FLUSH_VALUE;
      end else if (!eff_freeze) begin
        unique case (state_q)
          StEmpty: begin
            if (in_fire) begin
              state_q <= StOne;
              main_q  <= in_data_i;
            end
          end
          StOne: begin
            if (in_fire && out_fire) begin
              main_q <= in_data_i;
            end else if (in_fire) begin
              state_q <= StFull;
              skid_q  <= in_data_i;
            end else if (out_fire) begin
              state_q <= StEmpty;
              main_q  <= FLUSH_VALUE;
            end
          end
          StFull: begin
            if (out_fire) begin
              state_q <= StOne;
              main_q  <= skid_q;
              skid_q  <= FLUSH_VALUE;
            end
          end
          default: state_q <= StEmpty;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: occupancy model plus payload scoreboard on a
// FLUSH_PRIO=1 instance, with a FLUSH_PRIO=0 twin for the legacy-priority case.
module tb_pipe_stage_skid_reg;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_data;

  logic        in_ready_a, out_valid_a;
  logic [15:0] out_data_a;
  logic [1:0]  occ_a;
  logic [3:0]  stall_a;

  logic        in_ready_b, out_valid_b;
  logic [15:0] out_data_b;
  logic [1:0]  occ_b;
  logic [15:0] stall_b;

  int checks;
  int failures;
  int pop_cnt;

  logic [15:0] sb[$];
  int          m_occ;
  int          m_stall;
  logic        m_in_rdy, m_out_vld, m_in_fire, m_out_fire;
  logic [15:0] m_exp;

  pipe_stage_skid_reg #(
    .DATA_W(16), .FLUSH_VALUE(16'h0000), .FLUSH_PRIO(1'b1), .CNT_W(4)
  ) u_dut_a (
    .clk(clk), .rst(rst), .freeze_i(freeze), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_a), .in_data_i(in_data),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_data_o(out_data_a),
    .occupancy_o(occ_a), .stall_cnt_o(stall_a)
  );

  pipe_stage_skid_reg #(
    .DATA_W(16), .FLUSH_VALUE(16'h0000), .FLUSH_PRIO(1'b0), .CNT_W(16)
  ) u_dut_b (
    .clk(clk), .rst(rst), .freeze_i(freeze), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_b), .in_data_i(in_data),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_data_o(out_data_b),
    .occupancy_o(occ_b), .stall_cnt_o(stall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: inputs change just after posedge, so negedge sees the settled cycle.
  always @(negedge clk) begin
    if (rst) begin
      m_occ = 0;
      m_stall = 0;
      sb.delete();
    end else begin
      m_in_rdy   = (m_occ != 2) && !freeze && !flush;
      m_out_vld  = (m_occ != 0) && !freeze && !flush;
      m_in_fire  = m_in_rdy && in_valid;
      m_out_fire = m_out_vld && out_ready;
      checks++;
      if (in_ready_a !== m_in_rdy) begin
        failures++;
        $display("FAIL mon_in_ready t=%0t got=%b exp=%b", $time, in_ready_a, m_in_rdy);
      end
      checks++;
      if (out_valid_a !== m_out_vld) begin
        failures++;
        $display("FAIL mon_out_valid t=%0t got=%b exp=%b", $time, out_valid_a, m_out_vld);
      end
      checks++;
      if (occ_a !== 2'(m_occ)) begin
        failures++;
        $display("FAIL mon_occupancy t=%0t got=%0d exp=%0d", $time, occ_a, m_occ);
      end
      checks++;
      if (stall_a !== 4'(m_stall)) begin
        failures++;
        $display("FAIL mon_stall_cnt t=%0t got=%0d exp=%0d", $time, stall_a, m_stall);
      end
      if (m_occ == 0) begin
        checks++;
        if (out_data_a !== 16'h0000) begin
          failures++;
          $display("FAIL mon_empty_data t=%0t got=%h exp=0000", $time, out_data_a);
        end
      end
      if (m_out_fire) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL mon_unexpected_out t=%0t got=%h exp=none", $time, out_data_a);
        end else begin
          m_exp = sb.pop_front();
          pop_cnt++;
          if (out_data_a !== m_exp) begin
            failures++;
            $display("FAIL mon_out_data t=%0t got=%h exp=%h", $time, out_data_a, m_exp);
          end
        end
      end
      if (m_in_fire) sb.push_back(in_data);
      if ((m_occ != 0) && !m_out_fire && !flush && (m_stall != 15)) m_stall++;
      if (flush) begin
        m_occ = 0;
        sb.delete();
      end else if (!freeze) begin
        m_occ = m_occ + int'(m_in_fire) - int'(m_out_fire);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    freeze = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 16'h0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid_a, in_ready_a, occ_a} !== {1'b0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL reset_ctrl got=%b%b%0d exp=010", out_valid_a, in_ready_a, occ_a);
    end
    checks++;
    if ((out_data_a !== 16'h0) || (stall_a !== 4'd0)) begin
      failures++;
      $display("FAIL reset_data got=%h/%0d exp=0000/0", out_data_a, stall_a);
    end
    checks++;
    if ({out_valid_b, in_ready_b, occ_b, out_data_b, stall_b} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
      failures++;
      $display("FAIL reset_twin got=%b%b%0d %h %0d exp=010 0000 0",
               out_valid_b, in_ready_b, occ_b, out_data_b, stall_b);
    end
  endtask

  task automatic test_streaming();
    int start;
    do_reset();
    start = pop_cnt;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data = 16'(i);
      tick();
      checks++;
      if (occ_a !== 2'd1) begin
        failures++;
        $display("FAIL stream_occ i=%0d got=%0d exp=1", i, occ_a);
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (pop_cnt - start != 8) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=8", pop_cnt - start);
    end
    checks++;
    if (stall_a !== 4'd0) begin
      failures++;
      $display("FAIL stream_stall got=%0d exp=0", stall_a);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1;
    in_data = 16'h000A;
    tick();
    in_data = 16'h000B;
    tick();
    in_valid = 1'b0;
    checks++;
    if ((occ_a !== 2'd2) || (in_ready_a !== 1'b0)) begin
      failures++;
      $display("FAIL bp_full got=occ%0d/rdy%b exp=occ2/rdy0", occ_a, in_ready_a);
    end
    tick();
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_return got=%b exp=1", in_ready_a);
    end
    tick();
    checks++;
    if ((occ_a !== 2'd0) || (stall_a !== 4'd2)) begin
      failures++;
      $display("FAIL bp_drain got=occ%0d/stall%0d exp=occ0/stall2", occ_a, stall_a);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    in_valid = 1'b1;
    in_data = 16'h0055;
    tick();
    freeze = 1'b1;
    in_data = 16'h0066;
    out_ready = 1'b1;
    #1;
    checks++;
    if ((in_ready_a !== 1'b0) || (out_valid_a !== 1'b0)) begin
      failures++;
      $display("FAIL frz_gate got=rdy%b/vld%b exp=rdy0/vld0", in_ready_a, out_valid_a);
    end
    repeat (3) tick();
    checks++;
    if ((occ_a !== 2'd1) || (out_data_a !== 16'h0055) || (stall_a !== 4'd3)) begin
      failures++;
      $display("FAIL frz_hold got=occ%0d/%h/stall%0d exp=occ1/0055/stall3",
               occ_a, out_data_a, stall_a);
    end
    freeze = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_data_a !== 16'h0066) begin
      failures++;
      $display("FAIL frz_after got=%h exp=0066", out_data_a);
    end
    tick();
  endtask

  task automatic test_flush_full();
    int start;
    do_reset();
    in_valid = 1'b1;
    in_data = 16'h0011;
    tick();
    in_data = 16'h0022;
    tick();
    start = pop_cnt;
    flush = 1'b1;
    in_data = 16'h0033;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ((occ_a !== 2'd0) || (out_valid_a !== 1'b0) || (out_data_a !== 16'h0)) begin
      failures++;
      $display("FAIL flush_clear got=occ%0d/vld%b/%h exp=occ0/vld0/0000",
               occ_a, out_valid_a, out_data_a);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (pop_cnt != start) begin
      failures++;
      $display("FAIL flush_no_emit got=%0d exp=0", pop_cnt - start);
    end
  endtask

  task automatic test_flush_freeze();
    do_reset();
    in_valid = 1'b1;
    in_data = 16'h0077;
    tick();
    in_valid = 1'b0;
    freeze = 1'b1;
    flush = 1'b1;
    tick();
    freeze = 1'b0;
    flush = 1'b0;
    #1;
    checks++;
    if ((occ_a !== 2'd0) || (out_valid_a !== 1'b0)) begin
      failures++;
      $display("FAIL ff_prio1 got=occ%0d/vld%b exp=occ0/vld0", occ_a, out_valid_a);
    end
    checks++;
    if ((occ_b !== 2'd1) || (out_valid_b !== 1'b1) || (out_data_b !== 16'h0077)) begin
      failures++;
      $display("FAIL ff_prio0_hold got=occ%0d/vld%b/%h exp=occ1/vld1/0077",
               occ_b, out_valid_b, out_data_b);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ((occ_b !== 2'd0) || (out_data_b !== 16'h0)) begin
      failures++;
      $display("FAIL ff_prio0_emit got=occ%0d/%h exp=occ0/0000", occ_b, out_data_b);
    end
  endtask

  task automatic test_stall_sat_reset();
    do_reset();
    in_valid = 1'b1;
    in_data = 16'h0099;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    checks++;
    if (stall_a !== 4'd15) begin
      failures++;
      $display("FAIL stall_sat got=%0d exp=15", stall_a);
    end
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ((out_valid_a !== 1'b0) || (stall_a !== 4'd0) || (out_data_a !== 16'h0)
        || (occ_a !== 2'd0)) begin
      failures++;
      $display("FAIL async_reset got=vld%b/stall%0d/%h/occ%0d exp=vld0/stall0/0000/occ0",
               out_valid_a, stall_a, out_data_a, occ_a);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    pop_cnt = 0;
    m_occ = 0;
    m_stall = 0;
    rst = 1'b1;
    freeze = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 16'h0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_freeze();
    test_flush_full();
    test_flush_freeze();
    test_stall_sat_reset();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
